y86_fetch_aligner: RTL and testbench

Parametrised instruction-fetch aligner for the Y86-64 core. It accepts a stream of fixed-width, byte-ordered fetch beats from instruction memory and buffers them. It emits one whole variable-length Y86-64 instruction per handshake on the 80-bit `instr` bus that `top` consumes, together with its PC and length. Redirect (`flush`) and halt tracking are included.

---
 rtl/y86_fetch_aligner.sv | 114 +++++++++++
 tb/tb_y86_fetch_aligner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_aligner.sv
// Byte-buffered fetch aligner: packs fixed-width fetch beats into a circular byte
// buffer and presents one whole variable-length Y86-64 instruction per handshake.
module y86_fetch_aligner #(
  parameter int FETCH_BYTES = 4,
  parameter int DEPTH_BYTES = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*FETCH_BYTES-1:0] in_data,
  input  logic                     flush,
  input  logic [63:0]              flush_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [79:0]              instr,
  output logic [3:0]               instr_len,
  output logic [63:0]              instr_pc,
  output logic                     instr_err,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH_BYTES - FETCH_BYTES);

  logic [7:0]    buf_mem [DEPTH_BYTES];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [63:0]   pc_reg;
  logic          halted_reg;

  logic [7:0]    head [10];
  logic [3:0]    icode;
  logic [3:0]    len_dec;
  logic          head_valid;
  logic          push, pop;

  // The ten bytes starting at the head; a maximal instruction is ten bytes long.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_head
      assign head[gi] = buf_mem[rd_ptr_reg + AW'(gi)];
      assign instr[79-8*gi -: 8] = (head_valid && (4'(gi) < len_dec)) ? head[gi] : 8'h00;
    end
  endgenerate

  assign icode = head[0][7:4];

  always_comb begin
    len_dec = 4'd1;
    case (icode)
      4'h0, 4'h1, 4'h9:         len_dec = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:   len_dec = 4'd2;
      4'h7, 4'h8:               len_dec = 4'd9;
      4'h3, 4'h4, 4'h5:         len_dec = 4'd10;
      default:                  len_dec = 4'd1;
    endcase
  end

  assign head_valid = !halted_reg && (count_reg != '0) && (count_reg >= CW'(len_dec));
  assign in_ready   = (count_reg <= READY_MAX);

  // Flush (and reset) squash any handshake offered in the same cycle.
  assign push = in_valid && in_ready && !flush && !reset;
  assign pop  = head_valid && instr_ready && !flush && !reset;

  assign count_next = count_reg
                    + (push ? CW'(FETCH_BYTES) : '0)
                    - (pop  ? CW'(len_dec)     : '0);

  always_ff @(posedge clock) begin
    if (push) begin
      for (int j = 0; j < FETCH_BYTES; j++) begin
        buf_mem[wr_ptr_reg + AW'(j)] <= in_data[8*(FETCH_BYTES-j)-1 -: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      pc_reg     <= '0;
      halted_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      pc_reg     <= flush_pc;
      halted_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(FETCH_BYTES);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(len_dec);
        pc_reg     <= pc_reg + 64'(len_dec);
        if (icode == 4'h0) begin
          halted_reg <= 1'b1;
        end
      end
    end
  end

  assign instr_valid = head_valid;
  assign instr_len   = head_valid ? len_dec : 4'd0;
  assign instr_err   = head_valid && (icode > 4'hB);
  assign instr_pc    = pc_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_y86_fetch_aligner.sv
// Directed vector bench for y86_fetch_aligner (4-byte beats, 16-byte buffer).
module tb_y86_fetch_aligner;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic [63:0] flush_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [79:0] instr;
  logic [3:0]  instr_len;
  logic [63:0] instr_pc;
  logic        instr_err;
  logic        halted;

  always #5 clock = ~clock;

  y86_fetch_aligner #(.FETCH_BYTES(4), .DEPTH_BYTES(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_len(instr_len), .instr_pc(instr_pc),
    .instr_err(instr_err), .halted(halted)
  );

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic        ir;
    logic        fl;
    logic [63:0] fpc;
    logic        rdy;
    logic        vld;
    logic [79:0] ins;
    logic [3:0]  len;
    logic [63:0] pc;
    logic        err;
    logic        hlt;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic iv, input logic [31:0] data, input logic ir,
                              input logic fl, input logic [63:0] fpc, input logic rdy,
                              input logic vld, input logic [79:0] ins, input logic [3:0] len,
                              input logic [63:0] pc, input logic err, input logic hlt);
    vec_t v;
    v.iv = iv; v.data = data; v.ir = ir; v.fl = fl; v.fpc = fpc;
    v.rdy = rdy; v.vld = vld; v.ins = ins; v.len = len; v.pc = pc; v.err = err; v.hlt = hlt;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ir,
                       input logic fl, input logic [63:0] fpc);
    in_valid = iv; in_data = d; instr_ready = ir; flush = fl; flush_pc = fpc;
  endtask

  task automatic cyc(input logic iv, input logic [31:0] d, input logic ir);
    drive(iv, d, ir, 1'b0, 64'h0);
    step();
  endtask

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  initial begin
    // Row i: inputs applied during cycle i, outputs expected during that same cycle.
    vecs[0]  = mk(1, 32'hb09f0807, 1, 0, 0,      1, 0, 80'h0, 0, 64'd0, 0, 0);
    vecs[1]  = mk(1, 32'h06050403, 1, 0, 0,      1, 1, 80'hb09f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[2]  = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h0800_0000_0000_0000_0000, 1, 64'd2, 0, 0);
    vecs[3]  = mk(1, 32'h10101010, 1, 0, 0,      1, 0, 80'h0, 0, 64'd3, 0, 1);
    vecs[4]  = mk(0, 32'h0,        1, 1, 0,      1, 0, 80'h0, 0, 64'd3, 0, 1);
    vecs[5]  = mk(1, 32'h30f30a00, 1, 0, 0,      1, 0, 80'h0, 0, 64'd0, 0, 0);
    vecs[6]  = mk(1, 32'h00000000, 1, 0, 0,      1, 0, 80'h0, 0, 64'd0, 0, 0);
    vecs[7]  = mk(1, 32'h00001000, 0, 0, 0,      1, 0, 80'h0, 0, 64'd0, 0, 0);
    vecs[8]  = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h30f30a00000000000000, 10, 64'd0, 0, 0);
    vecs[9]  = mk(0, 32'h0,        0, 0, 0,      1, 1, 80'h1000_0000_0000_0000_0000, 1, 64'd10, 0, 0);
    vecs[10] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h1000_0000_0000_0000_0000, 1, 64'd10, 0, 0);
    vecs[11] = mk(0, 32'h0,        1, 1, 0,      1, 1, 80'h0, 1, 64'd11, 0, 0);
    vecs[12] = mk(1, 32'ha01f6023, 0, 0, 0,      1, 0, 80'h0, 0, 64'd0, 0, 0);
    vecs[13] = mk(1, 32'h20126134, 0, 0, 0,      1, 1, 80'ha01f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[14] = mk(1, 32'h62456367, 0, 0, 0,      1, 1, 80'ha01f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[15] = mk(1, 32'h20212223, 0, 0, 0,      1, 1, 80'ha01f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[16] = mk(1, 32'hdeadbeef, 0, 0, 0,      0, 1, 80'ha01f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[17] = mk(1, 32'hdeadbeef, 1, 0, 0,      0, 1, 80'ha01f_0000_0000_0000_0000, 2, 64'd0, 0, 0);
    vecs[18] = mk(0, 32'h0,        1, 0, 0,      0, 1, 80'h6023_0000_0000_0000_0000, 2, 64'd2, 0, 0);
    vecs[19] = mk(1, 32'h60af61bf, 1, 0, 0,      1, 1, 80'h2012_0000_0000_0000_0000, 2, 64'd4, 0, 0);
    vecs[20] = mk(0, 32'h0,        1, 0, 0,      0, 1, 80'h6134_0000_0000_0000_0000, 2, 64'd6, 0, 0);
    vecs[21] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h6245_0000_0000_0000_0000, 2, 64'd8, 0, 0);
    vecs[22] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h6367_0000_0000_0000_0000, 2, 64'd10, 0, 0);
    vecs[23] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h2021_0000_0000_0000_0000, 2, 64'd12, 0, 0);
    vecs[24] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h2223_0000_0000_0000_0000, 2, 64'd14, 0, 0);
    vecs[25] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h60af_0000_0000_0000_0000, 2, 64'd16, 0, 0);
    vecs[26] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h61bf_0000_0000_0000_0000, 2, 64'd18, 0, 0);
    vecs[27] = mk(1, 32'h1030f001, 0, 0, 0,      1, 0, 80'h0, 0, 64'd20, 0, 0);
    vecs[28] = mk(1, 32'h02030405, 0, 0, 0,      1, 1, 80'h1000_0000_0000_0000_0000, 1, 64'd20, 0, 0);
    vecs[29] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h1000_0000_0000_0000_0000, 1, 64'd20, 0, 0);
    vecs[30] = mk(1, 32'h10101010, 1, 1, 64'h100, 1, 0, 80'h0, 0, 64'd21, 0, 0);
    vecs[31] = mk(1, 32'hc0102000, 0, 0, 0,      1, 0, 80'h0, 0, 64'h100, 0, 0);
    vecs[32] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'hc000_0000_0000_0000_0000, 1, 64'h100, 1, 0);
    vecs[33] = mk(0, 32'h0,        1, 0, 0,      1, 1, 80'h1000_0000_0000_0000_0000, 1, 64'h101, 0, 0);
    vecs[34] = mk(0, 32'h0,        0, 0, 0,      1, 1, 80'h2000_0000_0000_0000_0000, 2, 64'h102, 0, 0);

    reset = 1'b1;
    drive(0, 32'h0, 0, 0, 64'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_state", {in_ready, instr_valid, instr, instr_len, instr_pc, instr_err, halted},
        {1'b1, 1'b0, 80'h0, 4'h0, 64'h0, 1'b0, 1'b0});

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].data, vecs[i].ir, vecs[i].fl, vecs[i].fpc);
      #1;
      n_vec++;
      if ({in_ready, instr_valid, instr, instr_len, instr_pc, instr_err, halted} !==
          {vecs[i].rdy, vecs[i].vld, vecs[i].ins, vecs[i].len, vecs[i].pc, vecs[i].err, vecs[i].hlt}) begin
        n_bad++;
        $display("FAIL vec%0d: got rdy=%b vld=%b instr=%h len=%0d pc=%h err=%b hlt=%b, expected rdy=%b vld=%b instr=%h len=%0d pc=%h err=%b hlt=%b",
                 i, in_ready, instr_valid, instr, instr_len, instr_pc, instr_err, halted,
                 vecs[i].rdy, vecs[i].vld, vecs[i].ins, vecs[i].len, vecs[i].pc, vecs[i].err, vecs[i].hlt);
      end else begin
        $display("ok   vec%0d: rdy=%b vld=%b instr=%h len=%0d pc=%h err=%b hlt=%b",
                 i, in_ready, instr_valid, instr, instr_len, instr_pc, instr_err, halted);
      end
      step();
    end

    // Reset while a complete jXX sits in the buffer with 9 bytes held.
    cyc(1, 32'h10101070, 0);
    cyc(1, 32'h11223344, 0);
    cyc(1, 32'h55667788, 0);
    drive(0, 32'h0, 1, 0, 64'h0);
    repeat (4) step();
    drive(0, 32'h0, 0, 0, 64'h0);
    #1;
    chk("jxx_head", {instr_valid, instr, instr_len, instr_pc},
        {1'b1, 80'h70112233445566778800, 4'd9, 64'h107});

    reset = 1'b1;
    drive(1, 32'h12345678, 1, 1, 64'h55);
    step();
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 64'h0);
    #1;
    chk("reset_mid", {in_ready, instr_valid, instr, instr_len, instr_pc, instr_err, halted},
        {1'b1, 1'b0, 80'h0, 4'h0, 64'h0, 1'b0, 1'b0});

    cyc(1, 32'h70010203, 0);
    cyc(1, 32'h04050607, 0);
    chk("refeed_wait", {instr_valid, instr_len}, {1'b0, 4'd0});
    cyc(1, 32'h08000000, 0);
    drive(0, 32'h0, 0, 0, 64'h0);
    #1;
    chk("refeed_jxx", {instr_valid, instr, instr_len, instr_pc},
        {1'b1, 80'h70010203040506070800, 4'd9, 64'h0});
    drive(0, 32'h0, 1, 0, 64'h0);
    step();
    drive(0, 32'h0, 0, 0, 64'h0);
    #1;
    chk("after_jxx", {instr_valid, instr_len, instr_pc}, {1'b1, 4'd1, 64'd9});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
